// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline-control definitions.
// Holds the stall controller state encoding, the multdiv timeout limit, counter widths and the
// encoded pipeline-control patterns driven by the controller.
package pipeline_stall_controller_pkg;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StMdBusy = 1'b1
  } state_e;

  // Number of frozen MD_BUSY cycles tolerated before the multdiv unit is declared hung.
  localparam int unsigned MdTimeout  = 40;
  localparam int unsigned WaitWidth  = 6;
  localparam int unsigned StallWidth = 32;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic dx_en;
    logic fd_flush;
    logic dx_nop;
    logic xm_nop;
  } ctrl_t;

  // Normal flow: everything advances, nothing squashed.
  localparam ctrl_t CtrlRun    = 6'b111_000;
  // Taken branch: wrong-path F and D instructions become nops, pipeline keeps moving.
  localparam ctrl_t CtrlSquash = 6'b111_110;
  // Load-use: hold PC and F/D, push a bubble into D/X.
  localparam ctrl_t CtrlBubble = 6'b001_010;
  // Multdiv in flight: hold front end, keep X/M filled with nops.
  localparam ctrl_t CtrlFreeze = 6'b000_001;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value.
// Ports:
//   i_clock  - clock, counts on rising edge
//   i_reset  - synchronous active-high clear
//   i_inc    - increment request for this cycle
//   o_count  - current count
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [Width-1:0] o_count
);

  logic [Width-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + Width'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: stall/flush sequencing for a 5-stage pipeline.
// Resolves load-use bubbles, taken-branch squashes and multi-cycle multdiv freezes, with a
// watchdog on the multdiv unit and a saturating count of stalled cycles.
// Ports:
//   i_clock, i_reset          - clock and synchronous active-high reset
//   i_load_use_hazard         - D/X load-use hazard detected
//   i_branch_taken            - taken branch/jump resolved in X
//   i_mult_div_start          - mult/div in X issued to the multdiv unit (pulse)
//   i_mult_div_ready          - multdiv result valid this cycle
//   o_pc_enable, o_fd_enable, o_dx_enable       - pipeline register write enables
//   o_fd_flush, o_dx_insert_nop, o_xm_insert_nop - nop injection controls
//   o_md_timeout              - sticky multdiv watchdog error
//   o_stall_cycles            - saturating count of cycles with PC held
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
(
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load_use_hazard,
  input  logic                  i_branch_taken,
  input  logic                  i_mult_div_start,
  input  logic                  i_mult_div_ready,
  output logic                  o_pc_enable,
  output logic                  o_fd_enable,
  output logic                  o_dx_enable,
  output logic                  o_fd_flush,
  output logic                  o_dx_insert_nop,
  output logic                  o_xm_insert_nop,
  output logic                  o_md_timeout,
  output logic [StallWidth-1:0] o_stall_cycles
);

  state_e               r_state;
  state_e               w_state_next;
  logic [WaitWidth-1:0] r_wait;
  logic [WaitWidth-1:0] w_wait_next;
  logic                 r_md_timeout;
  logic                 w_timeout_set;
  logic                 w_md_expired;
  ctrl_t                w_ctrl;

  // r_wait counts completed frozen MD_BUSY cycles; reaching the limit means the unit is hung.
  assign w_md_expired = (r_wait == WaitWidth'(MdTimeout));

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= StRun;
      r_wait       <= '0;
      r_md_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      if (w_timeout_set) begin
        r_md_timeout <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next  = r_state;
    w_wait_next   = r_wait;
    w_timeout_set = 1'b0;
    unique case (r_state)
      StRun: begin
        // A result ready in the issue cycle needs no busy phase at all.
        if (i_mult_div_start && !i_mult_div_ready) begin
          w_state_next = StMdBusy;
          w_wait_next  = '0;
        end
      end
      StMdBusy: begin
        if (i_mult_div_ready) begin
          w_state_next = StRun;
        end else if (w_md_expired) begin
          w_state_next  = StRun;
          w_timeout_set = 1'b1;
        end else begin
          w_wait_next = r_wait + WaitWidth'(1);
        end
      end
    endcase
  end

  // Mealy outputs; reset forces the normal-flow pattern.
  always_comb begin
    w_ctrl = CtrlRun;
    if (!i_reset) begin
      unique case (r_state)
        StRun: begin
          // Priority: multdiv issue > taken branch > load-use.
          if (i_mult_div_start) begin
            w_ctrl = i_mult_div_ready ? CtrlRun : CtrlFreeze;
          end else if (i_branch_taken) begin
            w_ctrl = CtrlSquash;
          end else if (i_load_use_hazard) begin
            w_ctrl = CtrlBubble;
          end
        end
        StMdBusy: begin
          // Release on ready or on watchdog expiry; other hazards are irrelevant while frozen.
          if (!i_mult_div_ready && !w_md_expired) begin
            w_ctrl = CtrlFreeze;
          end
        end
      endcase
    end
  end

  assign o_pc_enable     = w_ctrl.pc_en;
  assign o_fd_enable     = w_ctrl.fd_en;
  assign o_dx_enable     = w_ctrl.dx_en;
  assign o_fd_flush      = w_ctrl.fd_flush;
  assign o_dx_insert_nop = w_ctrl.dx_nop;
  assign o_xm_insert_nop = w_ctrl.xm_nop;
  assign o_md_timeout    = r_md_timeout;

  sat_counter #(
    .Width (StallWidth)
  ) u_stall_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (~w_ctrl.pc_en),
    .o_count (o_stall_cycles)
  );

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 clock  input  1  single processor clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-003 loadUseHazard  input  1  load-use hazard flag from the D/X load-output-to-ALU-input detector.
REQ-004 branchTaken  input  1  taken branch/jump resolved in X; younger F and D instructions are wrong-path.
REQ-005 multDivStart  input  1  one-cycle pulse: mult/div instruction in X has issued to the multdiv unit.
REQ-006 multDivReady  input  1  multdiv result valid this cycle.
REQ-007 pcEnable  output  1  PC register write enable.
REQ-008 fdEnable  output  1  F/D latch write enable.
REQ-009 dxEnable  output  1  D/X latch write enable.
REQ-010 fdFlush  output  1  load nop into F/D on next edge.
REQ-011 dxInsertNop  output  1  load nop into D/X on next edge.
REQ-012 xmInsertNop  output  1  load nop into X/M on next edge.
REQ-013 mdTimeout  output  1  sticky error: multdiv exceeded MD_TIMEOUT cycles.
REQ-014 stallCycles  output  32  saturating count of cycles with pcEnable=0.

Function
REQ-015 States SHALL be RUN, MD_BUSY; outputs Mealy (combinational from state and current inputs).
REQ-016 RUN, no event: pcEnable=fdEnable=dxEnable=1; fdFlush=dxInsertNop=xmInsertNop=0.
REQ-017 RUN, branchTaken=1: fdFlush=1, dxInsertNop=1, all enables 1; branch has priority over loadUseHazard (hazardous D instruction squashed, no stall).
REQ-018 RUN, loadUseHazard=1, branchTaken=0, multDivStart=0: pcEnable=0, fdEnable=0, dxInsertNop=1, dxEnable=1; one-cycle bubble; state stays RUN.
REQ-019 RUN, multDivStart=1: pcEnable=fdEnable=dxEnable=0, xmInsertNop=1; next state MD_BUSY unless multDivReady=1 in the same cycle, in which case RUN and no freeze applied (enables 1, xmInsertNop=0).
REQ-020 multDivStart SHALL take priority over branchTaken and loadUseHazard in the same cycle (a mult/div in X cannot be a branch).
REQ-021 MD_BUSY, multDivReady=0: pcEnable=fdEnable=dxEnable=0, xmInsertNop=1; branchTaken, loadUseHazard, multDivStart ignored.
REQ-022 MD_BUSY, multDivReady=1: all enables 1, xmInsertNop=0 (result written into X/M); next state RUN.
REQ-023 A 6-bit wait counter SHALL clear on entry to MD_BUSY and increment each MD_BUSY cycle; on reaching MD_TIMEOUT (40) with multDivReady=0, mdTimeout SHALL set, outputs follow REQ-022, next state RUN.
REQ-024 mdTimeout SHALL remain 1 until reset.
REQ-025 stallCycles SHALL increment by 1 each cycle pcEnable=0 and saturate at 0xFFFF_FFFF.

Reset
REQ-026 On reset: state RUN, wait counter 0, mdTimeout 0, stallCycles 0.
REQ-027 Reset asserted in MD_BUSY SHALL return to RUN at that edge with no further freeze; combinational outputs while reset=1 SHALL equal REQ-016 values.

Structure
REQ-028 State encoding and MD_TIMEOUT=40 SHALL live in a shared pipeline control package.
REQ-029 The saturating 32-bit counter SHALL be a sub-module named sat_counter (inputs clock, reset, inc; output count).
REQ-030 No other sub-modules; hazard detection stays external.

Verification
REQ-031 RUN, loadUseHazard=1 one cycle -> pcEnable=0, fdEnable=0, dxInsertNop=1 that cycle; next cycle enables 1; stallCycles=1.
REQ-032 loadUseHazard=1 and branchTaken=1 same cycle -> fdFlush=1, dxInsertNop=1, pcEnable=1; stallCycles unchanged.
REQ-033 multDivStart pulse, multDivReady after 17 MD_BUSY cycles -> freeze for 18 cycles total, xmInsertNop=1 each, stallCycles=18, state RUN after.
REQ-034 multDivStart with multDivReady never -> mdTimeout=1 after 40 MD_BUSY cycles, state RUN, mdTimeout stays 1 until reset.
REQ-035 reset asserted on 5th MD_BUSY cycle -> next cycle RUN, enables 1, stallCycles=0, mdTimeout=0.
REQ-036 stallCycles forced near saturation (sequence of 0xFFFF_FFFF+ stalled cycles, or backdoor preload) -> holds at 0xFFFF_FFFF.
